dsm_cic_decimator: RTL and testbench

DSM_CIC_DECIMATOR -- requirements
Module: dsm_cic_decimator

---
 rtl/dsm_pkg.sv | 14 +
 rtl/dsm_cic_stage.sv | 51 +++++
 rtl/dsm_cic_decimator.sv | 114 +++++++++++
 tb/tb_dsm_cic_decimator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma CIC reconstruction path.
//   CIC_ORDER  : number of integrator/comb pairs in the decimator
//   cic_width  : internal register width for a given input width and log2(R)
package dsm_pkg;

    localparam int CIC_ORDER = 3;

    // Bit growth of an N-th order CIC is N*log2(R*M) with M=1, so this width
    // holds the full-scale output; the integrators may wrap freely.
    function automatic int cic_width(input int in_w, input int log2_r);
        return in_w + CIC_ORDER * log2_r;
    endfunction

endpackage

// File: rtl/dsm_cic_stage.sv
// One integrator/comb pair of the CIC decimator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of both registers
//   int_en     : advance the integrator (accepted input sample)
//   int_in     : integrator input
//   int_out    : integrator sum including the current int_in (combinational)
//   comb_en    : advance the comb delay (decimated sample instant)
//   comb_in    : comb input
//   comb_out   : first difference comb_in - previous comb_in (combinational)
module dsm_cic_stage
    import dsm_pkg::*;
#(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         int_en,
    input  logic [W-1:0] int_in,
    output logic [W-1:0] int_out,
    input  logic         comb_en,
    input  logic [W-1:0] comb_in,
    output logic [W-1:0] comb_out
);

    logic [W-1:0] acc;
    logic [W-1:0] dly;

    // Modular two's-complement arithmetic: wrap in the integrators is
    // undone exactly by the combs as long as the final result fits in W.
    assign int_out  = acc + int_in;
    assign comb_out = comb_in - dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            dly <= '0;
        end else if (clear) begin
            acc <= '0;
            dly <= '0;
        end else begin
            if (int_en) begin
                acc <= int_out;
            end
            if (comb_en) begin
                dly <= comb_in;
            end
        end
    end

endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator reconstructing the fractional word from a
// MASH 1-1-1 modulator output stream.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronous clear of all state (wins over in_valid_i)
//   in_valid_i   : qualifies y_i; only accepted samples advance the filter
//   y_i          : signed modulator output sample
//   out_valid_o  : one-cycle pulse marking a new frac_o
//   frac_o       : signed result, WIDTH fractional bits, held between pulses
//   settled_o    : high from the third output pulse after reset/clear
// Build option: define DSM_CIC_SAT_EN to clamp frac_o to [0, 2^WIDTH-1].
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int IN_W   = 4,
    parameter int LOG2_R = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    input  logic [IN_W-1:0]       y_i,
    output logic                  out_valid_o,
    output logic [WIDTH+IN_W-1:0] frac_o,
    output logic                  settled_o
);

    localparam int IW    = cic_width(IN_W, LOG2_R);
    localparam int OW    = WIDTH + IN_W;
    localparam int SHIFT = IW - OW;

    logic              accept;
    logic              dump;
    logic [LOG2_R-1:0] dec_cnt;
    logic [1:0]        pulse_cnt;
    logic [IW-1:0]     int_link  [0:CIC_ORDER];
    logic [IW-1:0]     comb_link [0:CIC_ORDER];
    logic [OW-1:0]     frac_raw;
    logic [OW-1:0]     frac_next;

    assign accept = in_valid_i & ~clear_i;
    assign dump   = accept & (dec_cnt == '1);

    assign int_link[0]  = {{(IW-IN_W){y_i[IN_W-1]}}, y_i};
    // The last integrator's sum already includes the sample accepted this
    // cycle, so the R-th sample reaches the combs on its own edge.
    assign comb_link[0] = int_link[CIC_ORDER];

    for (genvar s = 0; s < CIC_ORDER; s++) begin : g_stage
        dsm_cic_stage #(
            .W(IW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear_i),
            .int_en   (accept),
            .int_in   (int_link[s]),
            .int_out  (int_link[s+1]),
            .comb_en  (dump),
            .comb_in  (comb_link[s]),
            .comb_out (comb_link[s+1])
        );
    end

    // Taking the top OW bits is the arithmetic right shift by SHIFT.
    assign frac_raw = comb_link[CIC_ORDER][IW-1:SHIFT];

`ifdef DSM_CIC_SAT_EN
    localparam logic [OW-1:0] SAT_MAX = {{IN_W{1'b0}}, {WIDTH{1'b1}}};

    always_comb begin
        frac_next = frac_raw;
        if (frac_raw[OW-1]) begin
            frac_next = '0;
        end else if (frac_raw > SAT_MAX) begin
            frac_next = SAT_MAX;
        end
    end
`else
    assign frac_next = frac_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt     <= '0;
            pulse_cnt   <= '0;
            out_valid_o <= 1'b0;
            frac_o      <= '0;
            settled_o   <= 1'b0;
        end else if (clear_i) begin
            dec_cnt     <= '0;
            pulse_cnt   <= '0;
            out_valid_o <= 1'b0;
            frac_o      <= '0;
            settled_o   <= 1'b0;
        end else begin
            out_valid_o <= dump;
            if (accept) begin
                dec_cnt <= dec_cnt + 1'b1;
            end
            if (dump) begin
                frac_o <= frac_next;
                // Comb delays hold real history after two dumps; the third
                // output is the first fully primed one.
                if (pulse_cnt != 2'd2) begin
                    pulse_cnt <= pulse_cnt + 2'd1;
                end else begin
                    settled_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
module tb_dsm_cic_decimator;

    localparam int R    = 256;
    localparam int HLEN = 3 * R - 2;
    localparam logic [23:0] MASH_X = 24'h400000;

`ifdef DSM_CIC_SAT_EN
    localparam longint CONST1_EXP = 64'sd16777215;
    localparam longint NEG3_EXP   = 64'sd0;
`else
    localparam longint CONST1_EXP = 64'sd16777216;
    localparam longint NEG3_EXP   = -64'sd50331648;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [3:0]  y = '0;
    logic               out_valid;
    logic signed [27:0] frac;
    logic               settled;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;

    longint p_frac[$];
    int     p_set[$];
    int     p_cnt[$];
    int     p_cyc[$];
    longint cont[$];

    int h2 [0:2*R];
    int h3 [0:3*R];

    // behavioural model state
    int                 hist[$];
    int                 m_cnt = 0;
    int                 m_npulse = 0;
    logic               m_valid = 1'b0;
    logic               m_settled = 1'b0;
    logic signed [27:0] m_frac = '0;

    // golden MASH 1-1-1 state
    logic [23:0] e1, e2, e3;
    int c2d, c3d, c3dd;

    dsm_cic_decimator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .y_i         (y),
        .out_valid_o (out_valid),
        .frac_o      (frac),
        .settled_o   (settled)
    );

    always #5 clk = ~clk;

    // Output = accepted-sample history convolved with boxcar(R)^3.
    function automatic logic signed [27:0] cic_out();
        longint s = 0;
        int n = hist.size();
        for (int k = 0; k < n; k++) s += longint'(h3[k]) * longint'(hist[n-1-k]);
`ifdef DSM_CIC_SAT_EN
        if (s < 0) s = 0;
        else if (s > 64'sd16777215) s = 64'sd16777215;
`endif
        return 28'(s);
    endfunction

    task automatic m_reset();
        hist.delete();
        m_cnt = 0;
        m_npulse = 0;
        m_valid = 1'b0;
        m_settled = 1'b0;
        m_frac = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else if (clear) begin
            m_reset();
        end else begin
            m_valid = 1'b0;
            if (in_valid) begin
                hist.push_back(int'(y));
                if (hist.size() > HLEN) void'(hist.pop_front());
                m_cnt++;
                if (m_cnt == R) begin
                    m_cnt = 0;
                    m_valid = 1'b1;
                    m_frac = cic_out();
                    m_npulse++;
                    if (m_npulse >= 3) m_settled = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (out_valid !== m_valid || settled !== m_settled || frac !== m_frac) begin
            n_err++;
            $display("FAIL model_cmp t=%0t: got valid=%0b settled=%0b frac=%0d, expected valid=%0b settled=%0b frac=%0d",
                     $time, out_valid, settled, frac, m_valid, m_settled, m_frac);
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_q();
        p_frac.delete();
        p_set.delete();
        p_cnt.delete();
        p_cyc.delete();
        acc_cnt = 0;
    endtask

    task automatic step(input logic v, input logic signed [3:0] yy, input logic clr);
        @(negedge clk);
        in_valid = v;
        y = yy;
        clear = clr;
        @(posedge clk);
        #1;
        cyc++;
        if (clr) acc_cnt = 0;
        else if (v) acc_cnt++;
        if (out_valid) begin
            p_frac.push_back(longint'(frac));
            p_set.push_back(int'(settled));
            p_cnt.push_back(acc_cnt);
            p_cyc.push_back(cyc);
            acc_cnt = 0;
        end
    endtask

    task automatic feed(input int n, input logic signed [3:0] yy);
        for (int i = 0; i < n; i++) step(1'b1, yy, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 4'sd0, 1'b1);
        clear_q();
    endtask

    task automatic mash_next(output logic signed [3:0] yo);
        logic [24:0] s;
        int c1, c2, c3, v;
        s = {1'b0, e1} + {1'b0, MASH_X}; c1 = int'(s[24]); e1 = s[23:0];
        s = {1'b0, e2} + {1'b0, e1};     c2 = int'(s[24]); e2 = s[23:0];
        s = {1'b0, e3} + {1'b0, e2};     c3 = int'(s[24]); e3 = s[23:0];
        v = c1 + (c2 - c2d) + (c3 - 2 * c3d + c3dd);
        c3dd = c3d; c3d = c3; c2d = c2;
        yo = 4'(v);
    endtask

    initial begin
        logic signed [3:0] ym;
        longint sum;

        for (int i = 0; i <= 2*R; i++) h2[i] = 0;
        for (int i = 0; i <= 3*R; i++) h3[i] = 0;
        for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) h2[i+j]++;
        for (int i = 0; i < 2*R-1; i++) for (int j = 0; j < R; j++) h3[i+j] += h2[i];

        // reset
        repeat (3) @(negedge clk);
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_frac", longint'(frac), 0);
        chk("rst_settled", longint'(settled), 0);
        rst_n = 1'b1;

        // constant +1, continuous
        clear_q();
        feed(6 * R, 4'sd1);
        chk("c1_npulse", p_frac.size(), 6);
        if (p_frac.size() >= 6) begin
            chk("c1_first_latency", p_cnt[0], R);
            chk("c1_settled_p1", p_set[0], 0);
            chk("c1_settled_p2", p_set[1], 0);
            chk("c1_settled_p3", p_set[2], 1);
            for (int k = 2; k < 6; k++) chk($sformatf("c1_frac_p%0d", k+1), p_frac[k], CONST1_EXP);
            for (int k = 0; k < 5; k++) cont.push_back(p_frac[k]);
        end

        // clear returns everything to zero
        do_clear();
        chk("clr_frac", longint'(frac), 0);
        chk("clr_settled", longint'(settled), 0);

        // in_valid toggling 1/0
        for (int i = 0; i < 10 * R; i++) step((i % 2) == 0, 4'sd1, 1'b0);
        chk("tog_npulse", p_frac.size(), 5);
        if (p_frac.size() >= 5 && cont.size() == 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("tog_val_p%0d", k+1), p_frac[k], cont[k]);
            for (int k = 1; k < 5; k++) chk($sformatf("tog_spacing_p%0d", k+1), p_cyc[k] - p_cyc[k-1], 2 * R);
        end

        // clear together with a valid sample mid-period
        feed(100, 4'sd1);
        step(1'b1, 4'sd1, 1'b1);
        clear_q();
        chk("cv_settled", longint'(settled), 0);
        feed(300, 4'sd1);
        chk("cv_npulse", p_frac.size(), 1);
        if (p_frac.size() >= 1) begin
            chk("cv_samples_to_pulse", p_cnt[0], R);
            chk("cv_settled_low", p_set[0], 0);
        end

        // constant -3
        do_clear();
        feed(5 * R, -4'sd3);
        chk("n3_npulse", p_frac.size(), 5);
        if (p_frac.size() >= 5) begin
            chk("n3_frac_p3", p_frac[2], NEG3_EXP);
            chk("n3_frac_p5", p_frac[4], NEG3_EXP);
        end

        // MASH 1-1-1 with x = 0x400000
        do_clear();
        e1 = '0; e2 = '0; e3 = '0; c2d = 0; c3d = 0; c3dd = 0;
        for (int i = 0; i < 68 * R; i++) begin
            mash_next(ym);
            step(1'b1, ym, 1'b0);
        end
        chk("mash_npulse", p_frac.size(), 68);
        if (p_frac.size() >= 68) begin
            sum = 0;
            for (int k = 4; k < 68; k++) sum += p_frac[k];
            n_checks++;
            if (sum < 64 * 64'sd4194304 - 64 || sum > 64 * 64'sd4194304 + 64) begin
                n_err++;
                $display("FAIL mash_avg: got sum %0d over 64 outputs, expected %0d +/- 64", sum, 64 * 64'sd4194304);
            end
        end

        // asynchronous reset mid-period
        feed(100, 4'sd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(out_valid), 0);
        chk("arst_frac", longint'(frac), 0);
        chk("arst_settled", longint'(settled), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        feed(300, 4'sd1);
        chk("arst_npulse", p_frac.size(), 1);
        if (p_frac.size() >= 1) chk("arst_samples_to_pulse", p_cnt[0], R);

        @(negedge clk);
        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
